// File: rtl/sumador_secuencial_param.sv
// Multi-cycle add/subtract unit: CHUNK bits per clock with a registered ripple carry,
// valid/ready on both sides. Define SUMADOR_SAT_EN to saturate the result on signed overflow.
module sumador_secuencial_param #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_ctrl;
  logic              r_cy;
  logic [CW-1:0]     r_cnt;
  logic [WIDTH-1:0]  r_result;
  logic              r_carry;
  logic              r_overflow;
  logic              r_zero;

  logic [IW-1:0]     w_base;
  logic [CHUNK:0]    w_sum;
  logic              w_last;
  logic [WIDTH-1:0]  w_res_nxt;
  logic [WIDTH-1:0]  w_final;
  logic              w_ovf;
  logic              w_cy_flag;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign carry     = r_carry;
  assign overflow  = r_overflow;
  assign zero      = r_zero;

  // Chunk adder and the result as it will look once this chunk is written
  always_comb begin
    w_base    = IW'(r_cnt * CHUNK);
    w_sum     = (CHUNK+1)'(r_a[w_base +: CHUNK]) + (CHUNK+1)'(r_b[w_base +: CHUNK])
              + (CHUNK+1)'(r_cy);
    w_last    = (r_cnt == LAST);
    w_res_nxt = r_result;
    w_res_nxt[w_base +: CHUNK] = w_sum[CHUNK-1:0];
    w_cy_flag = r_ctrl ? w_sum[CHUNK] : ~w_sum[CHUNK];
    // r_b already holds the effective (inverted for subtract) operand
    w_ovf     = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_res_nxt[WIDTH-1] != r_a[WIDTH-1]);
`ifdef SUMADOR_SAT_EN
    if (w_ovf) begin
      w_final = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      w_final = w_res_nxt;
    end
`else
    w_final   = w_res_nxt;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, chunk-serial accumulation and flag latch on the last chunk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_ctrl     <= 1'b0;
      r_cy       <= 1'b0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a    <= a;
            r_b    <= control ? b : ~b;
            r_ctrl <= control;
            r_cy   <= ~control;
            r_cnt  <= '0;
          end
        end
        S_RUN: begin
          r_cy  <= w_sum[CHUNK];
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_result   <= w_final;
            r_carry    <= w_cy_flag;
            r_overflow <= w_ovf;
            r_zero     <= (w_final == '0);
          end else begin
            r_result   <= w_res_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sumador_secuencial_param.sv
// Scoreboard bench for sumador_secuencial_param (16/4 instance plus a 16/16 single-chunk instance).
module tb_sumador_secuencial_param;

  typedef struct packed {
    logic [15:0] res;
    logic        c;
    logic        o;
    logic        z;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        control = 1'b1;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] result;
  logic        carry, overflow, zero;

  logic        in_valid2 = 1'b0;
  logic        in_ready2;
  logic [15:0] a2 = '0;
  logic [15:0] b2 = '0;
  logic        control2 = 1'b1;
  logic        out_valid2;
  logic        out_ready2 = 1'b1;
  logic [15:0] result2;
  logic        carry2, overflow2, zero2;

  int   total = 0;
  int   bad = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  sumador_secuencial_param #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .control(control), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry(carry), .overflow(overflow), .zero(zero)
  );

  sumador_secuencial_param #(.WIDTH(16), .CHUNK(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
    .control(control2), .out_valid(out_valid2), .out_ready(out_ready2), .result(result2),
    .carry(carry2), .overflow(overflow2), .zero(zero2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted result is popped and compared
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mon_unexpected: got result %0h with no expected entry", result);
      end else begin
        e = q.pop_front();
        chk("mon_result",   32'(result),   32'(e.res));
        chk("mon_carry",    32'(carry),    32'(e.c));
        chk("mon_overflow", 32'(overflow), 32'(e.o));
        chk("mon_zero",     32'(zero),     32'(e.z));
      end
    end
  end

  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                       input logic [15:0] er, input logic ec, input logic eo, input logic ez);
    int n;
    exp_t e;
    e.res = er; e.c = ec; e.o = eo; e.z = ez;
    q.push_back(e);
    a = ia; b = ib; control = ic; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'd4);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("return_idle", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n;
    #1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result",    32'(result),    32'd0);
    chk("rst_flags",     32'({carry, overflow, zero}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    issue(16'h1234, 16'h0FFF, 1'b1, 16'h2233, 1'b0, 1'b0, 1'b0); wait_idle();
`ifdef SUMADOR_SAT_EN
    issue(16'h7FFF, 16'h0001, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0); wait_idle();
`else
    issue(16'h7FFF, 16'h0001, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0); wait_idle();
`endif
    issue(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0); wait_idle();
`ifdef SUMADOR_SAT_EN
    issue(16'h8000, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0); wait_idle();
`else
    issue(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0); wait_idle();
`endif
    issue(16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1); wait_idle();
    issue(16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1); wait_idle();

    // Backpressure: result and flags held while inputs wiggle
    out_ready = 1'b0;
    issue(16'hA5A5, 16'h5A5A, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      a = 16'($urandom); b = 16'($urandom); control = i[0]; in_valid = ~i[0];
      @(posedge clk); #1;
      chk("hold_result",    32'(result),    32'hFFFF);
      chk("hold_flags",     32'({carry, overflow, zero}), 32'd0);
      chk("hold_in_ready",  32'(in_ready),  32'd0);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);

    // Reset during the second RUN cycle discards the operation
    a = 16'h1111; b = 16'h2222; control = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result",    32'(result),    32'd0);
    chk("midrst_flags",     32'({carry, overflow, zero}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    issue(16'h0001, 16'h0001, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0); wait_idle();

    // Single-chunk instance: one RUN cycle
    a2 = 16'hFFFF; b2 = 16'h0001; control2 = 1'b1; in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    n = 0;
    while (!out_valid2 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("n1_latency",  32'(n),         32'd1);
    chk("n1_result",   32'(result2),   32'd0);
    chk("n1_carry",    32'(carry2),    32'd1);
    chk("n1_zero",     32'(zero2),     32'd1);
    chk("n1_overflow", 32'(overflow2), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sumador_secuencial_param.md
# sumador_secuencial_param

Parametrised, multi-cycle add/subtract unit that processes its operands `CHUNK` bits per clock with a registered ripple carry. It trades latency for area and timing on wide datapaths. It accepts one operation through a valid/ready input handshake and returns the result with carry/borrow, signed-overflow and zero flags through a valid/ready output handshake. It is the successor of the 16-bit combinational adder/subtractor and sits in the datapath wherever wide operands would otherwise create a long combinational carry chain.

## Interface
- `WIDTH`, 16: operand/result width; must be a multiple of `CHUNK`.
- `CHUNK`, 4: bits added per cycle; `NCHUNK = WIDTH/CHUNK` cycles per operation.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  operation request.
- `in_ready`  output  1  high only in IDLE.
- `a`  input  WIDTH  operand A.
- `b`  input  WIDTH  operand B.
- `control`  input  1  0 = subtract (a-b), 1 = add (a+b).
- `out_valid`  output  1  result valid; high only in DONE.
- `out_ready`  input  1  consumer accepts result.
- `result`  output  WIDTH  registered result.
- `carry`  output  1  add: unsigned carry-out; subtract: borrow (1 when a < b unsigned).
- `overflow`  output  1  signed two's-complement overflow.
- `zero`  output  1  final `result` == 0.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_valid` high: capture `a`, `b` (or `~b` when `control`=0) and `control`.
  - Set carry register = `~control`, chunk counter = 0, go to RUN.
- RUN:
  - Each cycle, add chunk `k` of the captured A and B plus the carry register.
  - Write the CHUNK-bit sum into bits [k*CHUNK +: CHUNK] of `result`; store the chunk carry-out.
  - On the last chunk (k = NCHUNK-1), go to DONE.
- DONE: outputs are stable. `out_valid`=1. When `out_ready`=1, go to IDLE.
- Flags, computed once when entering DONE:
  - `carry` = final carry-out when adding; its inverse when subtracting.
  - `overflow` = (sign A == sign of effective B) && (sign result != sign A), where effective B is the inverted B for subtract.
  - `zero` is evaluated on the final (possibly saturated) `result`.
- Operand inputs and `control` are ignored outside IDLE. No new operation is accepted in DONE.
- Width rules:
  - Arithmetic is modulo 2^WIDTH.
  - Carry out of the top chunk feeds only `carry`/`overflow`.
  - The counter is ceil(log2(NCHUNK)) bits, min 1. NCHUNK = 1 is legal (single RUN cycle).
- Reset, at any time including mid-RUN:
  - State returns to IDLE immediately; the in-flight operation is discarded.
  - Reset values: `in_ready`=1, `out_valid`=0, `result`=0, `carry`=0, `overflow`=0, `zero`=0.

## Timing
- The accept edge is the rising edge with IDLE && `in_valid`. `out_valid` rises NCHUNK edges later (16/4: 4 cycles).
- `in_ready` and `out_valid` decode directly from the state register; there is no combinational path from inputs to outputs.
- Result hold: `out_valid`, `result` and the flags stay stable until the edge where `out_valid`&&`out_ready` is true. `in_ready` rises the following cycle.
- Minimum issue interval: NCHUNK+2 cycles with `out_ready` tied high.

## Configuration
- `SUMADOR_SAT_EN` defined: on signed overflow, `result` saturates to 0 followed by all-ones (max positive) if sign A = 0, else 1 followed by zeros (min negative). `overflow` still reads 1; `carry` is unchanged.
- Not defined: `result` wraps modulo 2^WIDTH. No saturation logic is synthesised.

## Test plan
All cases use WIDTH=16, CHUNK=4.
- Add 0x1234 + 0x0FFF -> `result`=0x2233, `carry`=0, `overflow`=0, `zero`=0; `out_valid` exactly 4 cycles after the accept edge.
- Add 0x7FFF + 0x0001 -> `overflow`=1, `carry`=0; `result`=0x8000 without the macro, 0x7FFF with `SUMADOR_SAT_EN`.
- Subtract 0x0000 - 0x0001 -> `result`=0xFFFF, `carry`(borrow)=1, `overflow`=0. Subtract 0x8000 - 0x0001 -> `overflow`=1, `result`=0x7FFF without the macro, 0x8000 with it.
- Add 0xFFFF + 0x0001 -> `result`=0x0000, `carry`=1, `zero`=1, `overflow`=0; repeat with CHUNK=16 (NCHUNK=1) -> same result, latency 1.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE while toggling `a`/`b`/`in_valid` -> `result` and flags unchanged, `in_ready`=0; release `out_ready` -> `in_ready`=1 the next cycle.
- Assert `rst_n`=0 during the 2nd RUN cycle -> outputs take their reset values immediately, FSM in IDLE. A following add of 0x0001 + 0x0001 yields 0x0002 with clean flags.
